// File: rtl/mcycle_wb_pkg.sv
// Shared types and constants for the multi-cycle write-back queue.
package mcycle_wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int REG_COUNT = 16;

  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [3:0] r);
    return REG_COUNT'(1) << r;
  endfunction

endpackage

// File: rtl/mcycle_wb_queue_fifo.sv
// wb_fifo: dual-push / single-pop circular buffer of write-back entries.
// push1 is only ever asserted together with push0; entry0 lands first.
module wb_fifo
  import mcycle_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push0,
  input  logic                 push1,
  input  logic                 pop,
  input  wb_entry_t            entry0,
  input  wb_entry_t            entry1,
  output wb_entry_t            head,
  output logic [AW:0]          count,
  output logic [REG_COUNT-1:0] mask
);

  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   head_ptr;
  logic [AW-1:0]   tail_ptr;
  logic [AW-1:0]   offs;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + AW'(pop);
      tail_ptr <= tail_ptr + AW'(push0) + AW'(push1);
      count    <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Storage carries no reset; occupancy is tracked purely by count.
  always_ff @(posedge clk) begin
    if (push0) mem[tail_ptr] <= entry0;
    if (push1) mem[tail_ptr + AW'(1)] <= entry1;
  end

  assign head = mem[head_ptr];

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    mask = '0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - head_ptr;
      if (CW'(offs) < count) mask = mask | reg_onehot(mem[i].wa);
    end
  end

endmodule

// File: rtl/mcycle_wb_queue.sv
// Write-back queue for FMUL/MCycle completions into the register-file port.
// Optional zero-latency bypass when the queue is empty: define WB_BYPASS_EN.
module mcycle_wb_queue
  import mcycle_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 FMULBusy,
  input  logic [31:0]          FMULResult,
  input  logic [3:0]           FMULWA3,
  input  logic                 MCBusy,
  input  logic [31:0]          MCResult,
  input  logic [3:0]           MCWA3,
  input  logic                 PipeWE,
  output logic                 WE3,
  output logic [3:0]           WA3,
  output logic [31:0]          WD3,
  output logic                 Full,
  output logic [REG_COUNT-1:0] PendMask,
  output logic                 Overflow
);

  localparam int CW = AW + 1;
  localparam int FW = AW + 2;

  logic                 fbusy_q;
  logic                 mbusy_q;
  logic                 fdone;
  logic                 mdone;
  logic                 byp_f;
  logic                 byp_m;
  logic                 req_f;
  logic                 req_m;
  logic [1:0]           n_req;
  logic                 pop;
  logic                 push0;
  logic                 push1;
  logic                 drop;
  logic [FW-1:0]        free_slots;
  wb_entry_t            f_ent;
  wb_entry_t            m_ent;
  wb_entry_t            entry0;
  wb_entry_t            head;
  logic [CW-1:0]        count;
  logic [REG_COUNT-1:0] fifo_mask;

  always_comb begin
    fdone = fbusy_q & ~FMULBusy;
    mdone = mbusy_q & ~MCBusy;
    f_ent = '{wa: FMULWA3, data: FMULResult};
    m_ent = '{wa: MCWA3, data: MCResult};

    byp_f = 1'b0;
    byp_m = 1'b0;
`ifdef WB_BYPASS_EN
    // Empty queue and a free port: FMUL takes the bypass, MCycle only if alone.
    if (count == '0 && !PipeWE && !Reset) begin
      byp_f = fdone;
      byp_m = mdone & ~fdone;
    end
`else
    byp_f = 1'b0;
    byp_m = 1'b0;
`endif

    req_f = fdone & ~byp_f;
    req_m = mdone & ~byp_m;
    n_req = {1'b0, req_f} + {1'b0, req_m};

    pop        = (count != '0) & ~PipeWE & ~Reset;
    free_slots = FW'(DEPTH) - FW'(count) + FW'(pop);

    // The earlier request (FMUL when both) always claims the first free slot.
    push0  = ~Reset & (n_req != 2'd0) & (free_slots != '0);
    push1  = ~Reset & (n_req == 2'd2) & (free_slots >= FW'(2));
    drop   = ~Reset & (FW'(n_req) > free_slots);
    entry0 = req_f ? f_ent : m_ent;

    WE3 = pop;
    WA3 = (count != '0) ? head.wa : 4'd0;
    WD3 = (count != '0) ? head.data : 32'd0;
    if (byp_f || byp_m) begin
      WE3 = 1'b1;
      WA3 = byp_f ? f_ent.wa : m_ent.wa;
      WD3 = byp_f ? f_ent.data : m_ent.data;
    end

    Full = (count > CW'(DEPTH - 2));

    PendMask = fifo_mask;
    if (FMULBusy) PendMask = PendMask | reg_onehot(FMULWA3);
    if (MCBusy)   PendMask = PendMask | reg_onehot(MCWA3);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fbusy_q  <= 1'b0;
      mbusy_q  <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      fbusy_q <= FMULBusy;
      mbusy_q <= MCBusy;
      if (drop) Overflow <= 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk    (CLK),
    .rst    (Reset),
    .push0  (push0),
    .push1  (push1),
    .pop    (pop),
    .entry0 (entry0),
    .entry1 (m_ent),
    .head   (head),
    .count  (count),
    .mask   (fifo_mask)
  );

endmodule
